// File: rtl/wrapper_wr_arbiter.sv
// ----------------------------------------------------------------------------
// wrapper_wr_arbiter
//
// Round-robin write arbiter. N_REQ producers in the clk_1 domain share the
// write port (data_1 / data_1_en / buffer_full) of the dual-clock buffer
// wrapper. At most one word is granted per cycle and nothing is written while
// the buffer reports full. A saturating counter records the cycles in which
// at least one producer was blocked by a full buffer.
//
// Optional feature: define ARB_BURST_EN to give each grant a tenure of up to
// BURST_LEN words for the same requester. Without the macro every grant is a
// single word and the round-robin pointer advances after each one.
//
// Ports
//   clk_i          write-side clock (buffer clk_1)
//   rst_i          synchronous reset, active-high
//   req_i          req_i[i]=1: requester i presents a valid word
//   req_data_i     word of requester i at [i*DATA_W +: DATA_W]
//   ack_o          one-hot, combinational: word of requester i taken this edge
//   buffer_full_i  buffer write-side full flag
//   data_1_en_o    write enable to the buffer (= |ack_o)
//   data_1_o       write data to the buffer (0 when nothing is granted)
//   grant_id_o     registered index of the last granted requester
//   stall_cnt_o    saturating count of cycles with |req_i && buffer_full_i
//   stall_clr_i    synchronous clear of stall_cnt_o (wins over the increment)
// ----------------------------------------------------------------------------
module wrapper_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*DATA_W-1:0]    req_data_i,
    output logic [N_REQ-1:0]           ack_o,
    input  logic                       buffer_full_i,
    output logic                       data_1_en_o,
    output logic [DATA_W-1:0]          data_1_o,
    output logic [$clog2(N_REQ)-1:0]   grant_id_o,
    output logic [15:0]                stall_cnt_o,
    input  logic                       stall_clr_i
);

    localparam int unsigned IdW  = $clog2(N_REQ);
    localparam int unsigned CntW = $clog2(BURST_LEN + 1);

`ifdef ARB_BURST_EN
    localparam bit BurstEn = 1'b1;
`else
    localparam bit BurstEn = 1'b0;
`endif

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e            state_q, state_d;
    logic [IdW-1:0]    ptr_q, ptr_d;
    logic [IdW-1:0]    owner_q, owner_d;
    logic [CntW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [IdW-1:0]    grant_id_q, grant_id_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic [N_REQ-1:0]  owner_mask;
    logic [N_REQ-1:0]  eligible;
    logic              owner_req;
    logic              found;
    logic [IdW-1:0]    winner;
    logic [IdW-1:0]    winner_inc;
    logic              grant;
    int unsigned       scan_idx;

    // ------------------------------------------------------------------------
    // Winner selection: first eligible requester starting at ptr_q, wrapping.
    // During a burst tenure only the owner is eligible.
    // ------------------------------------------------------------------------
    always_comb begin
        owner_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            owner_mask[i] = (owner_q == IdW'(i));
        end
        owner_req = |(req_i & owner_mask);

        eligible = req_i;
        if (state_q == StBurst) begin
            eligible = req_i & owner_mask;
        end

        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = (32'(ptr_q) + k) % N_REQ;
            if (!found && eligible[IdW'(scan_idx)]) begin
                found  = 1'b1;
                winner = IdW'(scan_idx);
            end
        end

        winner_inc = IdW'((32'(winner) + 1) % N_REQ);
        grant      = !rst_i && !buffer_full_i && found;
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state. A tenure ends when the owner drops its request or when
    // the grant that fills the tenure has just been given. ptr_d tracks the
    // last winner + 1 on every grant, which equals owner + 1 at tenure end.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;

        case (state_q)
            StIdle: begin
                // A tenure of one word is just a single grant, so stay idle.
                if (grant && BurstEn && (BURST_LEN > 1)) begin
                    state_d     = StBurst;
                    owner_d     = winner;
                    burst_cnt_d = CntW'(1);
                end
            end
            StBurst: begin
                if (grant) begin
                    if (burst_cnt_q == CntW'(BURST_LEN - 1)) begin
                        state_d     = StIdle;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else if (!owner_req) begin
                    state_d     = StIdle;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = StIdle;
                burst_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM outputs: zero-latency grant to the buffer write port.
    // ------------------------------------------------------------------------
    always_comb begin
        ack_o       = '0;
        data_1_o    = '0;
        data_1_en_o = grant;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant && (winner == IdW'(i))) begin
                ack_o[i] = 1'b1;
                data_1_o = req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pointer, last grant and stall counter
    // ------------------------------------------------------------------------
    always_comb begin
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        stall_cnt_d = stall_cnt_q;

        if (grant) begin
            ptr_d      = winner_inc;
            grant_id_d = winner;
        end

        if (stall_clr_i) begin
            stall_cnt_d = '0;
        end else if (buffer_full_i && (|req_i) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            grant_id_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant_id_o  = grant_id_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_wrapper_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wrapper_wr_arbiter
//
// Directed vector table (reset, streaming, round-robin order, full/stall,
// burst tenure when ARB_BURST_EN is defined) followed by randomized traffic
// checked against a tenure/pointer reference model.
// ----------------------------------------------------------------------------
module tb_wrapper_wr_arbiter;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int BLEN = 4;

`ifdef ARB_BURST_EN
    localparam bit BurstEn = 1'b1;
`else
    localparam bit BurstEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*W-1:0]    req_data;
    logic [N-1:0]      ack;
    logic              buffer_full;
    logic              data_1_en;
    logic [W-1:0]      data_1;
    logic [1:0]        grant_id;
    logic [15:0]       stall_cnt;
    logic              stall_clr;

    always #5 clk = ~clk;

    wrapper_wr_arbiter #(
        .N_REQ     (N),
        .DATA_W    (W),
        .BURST_LEN (BLEN)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .req_data_i    (req_data),
        .ack_o         (ack),
        .buffer_full_i (buffer_full),
        .data_1_en_o   (data_1_en),
        .data_1_o      (data_1),
        .grant_id_o    (grant_id),
        .stall_cnt_o   (stall_cnt),
        .stall_clr_i   (stall_clr)
    );

    typedef struct {
        logic           rst;
        logic           clr;
        logic           full;
        logic [N-1:0]   req;
        logic [N*W-1:0] data;
        int             exp_id;     // -1: nothing granted
        int             exp_gid;
        int             exp_stall;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: pointer, remaining words of the current tenure, owner.
    int m_ptr, m_owner, m_left, m_gid, m_stall;

    function automatic vec_t mk(input logic r, input logic c, input logic f,
                                input logic [N-1:0] q, input logic [N*W-1:0] d,
                                input int id, input int gid, input int st);
        vec_t v;
        v.rst = r; v.clr = c; v.full = f; v.req = q; v.data = d;
        v.exp_id = id; v.exp_gid = gid; v.exp_stall = st;
        return v;
    endfunction

    function automatic int m_winner(input logic r, input logic f, input logic [N-1:0] q);
        if (r || f) return -1;
        if (m_left > 0) return q[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (q[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic m_update(input logic r, input logic c, input logic f, input logic [N-1:0] q);
        int w;
        w = m_winner(r, f, q);
        if (r) begin
            m_ptr = 0; m_owner = 0; m_left = 0; m_gid = 0; m_stall = 0;
        end else begin
            if (c) m_stall = 0;
            else if (f && (q != 0) && m_stall < 65535) m_stall++;
            if (w >= 0) begin
                m_gid = w;
                m_ptr = (w + 1) % N;
                if (BurstEn) begin
                    if (m_left > 0) m_left--;
                    else begin
                        m_owner = w;
                        m_left  = BLEN - 1;
                    end
                end
            end else if (m_left > 0 && !q[m_owner]) begin
                m_left = 0;
            end
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic c, input logic f,
                         input logic [N-1:0] q, input logic [N*W-1:0] d);
        @(negedge clk);
        rst = r; stall_clr = c; buffer_full = f; req = q; req_data = d;
        #1;
    endtask

    task automatic check_all(input string tag, input int id, input int gid, input int st,
                             input logic [N*W-1:0] d);
        logic [N-1:0] e_ack;
        logic [W-1:0] e_dat;
        e_ack = '0;
        e_dat = '0;
        if (id >= 0) begin
            e_ack[id] = 1'b1;
            e_dat     = d[id*W +: W];
        end
        check({tag, ".ack"},       longint'(ack),       longint'(e_ack));
        check({tag, ".data_1_en"}, longint'(data_1_en), longint'(id >= 0));
        check({tag, ".data_1"},    longint'(data_1),    longint'(e_dat));
        check({tag, ".grant_id"},  longint'(grant_id),  longint'(gid));
        check({tag, ".stall_cnt"}, longint'(stall_cnt), longint'(st));
    endtask

    task automatic finish_cycle;
        m_update(rst, stall_clr, buffer_full, req);
        @(posedge clk);
    endtask

    initial begin : main
        logic [N*W-1:0] d3;
        logic [N-1:0]   rq;
        logic [N*W-1:0] rd;
        int             w;

        rst = 1'b1; stall_clr = 1'b0; buffer_full = 1'b0; req = '0; req_data = '0;
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        finish_cycle();

        d3 = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
`ifndef ARB_BURST_EN
        // Reset forcing, then a single producer streaming 1..8 without gaps.
        tbl.push_back(mk(1, 0, 0, 4'b1111, d3, -1, 0, 0));
        for (int k = 1; k <= 8; k++) tbl.push_back(mk(0, 0, 0, 4'b0001, 64'(k), 0, 0, 0));
        // Round-robin order from a fresh pointer.
        tbl.push_back(mk(1, 0, 0, 4'b0000, d3, -1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1111, d3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1111, d3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1111, d3, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1111, d3, 3, 2, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1111, d3, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1111, d3, 1, 0, 0));
        // Full buffer stalls and counts, grant on first non-full cycle.
        tbl.push_back(mk(0, 0, 1, 4'b0100, d3, -1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 4'b0100, d3, -1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 4'b0100, d3, -1, 1, 2));
        tbl.push_back(mk(0, 0, 0, 4'b0100, d3, 2, 1, 3));
        // Full without requests does not count; clear; clear beats increment.
        tbl.push_back(mk(0, 0, 1, 4'b0000, d3, -1, 2, 3));
        tbl.push_back(mk(0, 1, 0, 4'b0000, d3, -1, 2, 3));
        tbl.push_back(mk(0, 0, 0, 4'b0000, d3, -1, 2, 0));
        tbl.push_back(mk(0, 1, 1, 4'b0010, d3, -1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0000, d3, -1, 2, 0));
        // Requests arriving while full are served in order from ptr (=3).
        tbl.push_back(mk(0, 0, 1, 4'b1010, d3, -1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1010, d3, 3, 2, 1));
        tbl.push_back(mk(0, 0, 0, 4'b0010, d3, 1, 3, 1));
`else
        // Tenures of four words alternate between requesters 0 and 1.
        tbl.push_back(mk(1, 0, 0, 4'b0011, d3, -1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0011, d3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0011, d3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0011, d3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0011, d3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0011, d3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0011, d3, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0011, d3, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0011, d3, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0011, d3, 0, 1, 0));
        // Full mid-burst keeps ownership.
        tbl.push_back(mk(0, 0, 1, 4'b0011, d3, -1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0011, d3, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'b0011, d3, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'b0011, d3, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'b0011, d3, 1, 0, 1));
        // Reset after two words of requester 1; tenure restarts from ptr 0.
        tbl.push_back(mk(0, 0, 0, 4'b0010, d3, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 4'b1010, d3, -1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 4'b1010, d3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1010, d3, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1010, d3, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1010, d3, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1010, d3, 3, 1, 0));
`endif

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].clr, tbl[i].full, tbl[i].req, tbl[i].data);
            check_all($sformatf("vec%0d", i), tbl[i].exp_id, tbl[i].exp_gid,
                      tbl[i].exp_stall, tbl[i].data);
            finish_cycle();
        end

        // Randomized traffic: producers hold req/data until acked.
        rq = '0;
        rd = '0;
        w  = -1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic r, c, f;
            for (int i = 0; i < N; i++) begin
                if (w == i || !rq[i]) begin
                    rq[i] = ($urandom_range(2) != 0);
                    rd[i*W +: W] = W'($urandom);
                end else if ($urandom_range(15) == 0) begin
                    rq[i] = 1'b0;
                end
            end
            r = ($urandom_range(99) == 0);
            c = ($urandom_range(31) == 0);
            f = ($urandom_range(9) < 3);
            drive(r, c, f, rq, rd);
            w = m_winner(r, f, rq);
            check_all($sformatf("rnd%0d", cyc), w, m_gid, m_stall, rd);
            finish_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
